top_mac_row_acc: RTL
====================

# top_mac_row_acc

Row accumulator stage that feeds and consumes the 13x6 unsigned DSP multiplier (`top_mul_mul_13ns_cud`) in the GCN aggregation datapath. It accepts (feature, weight) operand pairs over a valid/ready handshake and drives the multiplier operands and `ce`. It tracks validity through the multiplier's fixed 2-cycle latency and sums the 19-bit products of each row. At the row's `in_last` term it emits one saturated sum plus a term count over a valid/ready output.

## Interface
- `ACC_W`, 32: accumulator and `out_sum` width; must be ≥ 19.
- `CNT_W`, 16: term counter and `out_cnt` width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- `clear`  in  1  synchronous abort: drop in-flight terms and any pending result.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept.
- `in_a`  in  13  unsigned feature operand.
- `in_b`  in  6  unsigned weight operand.
- `in_last`  in  1  final term of the row.
- `mul_ce`  out  1  multiplier clock enable.
- `mul_din0`  out  13  multiplier A operand; equals `in_a`.
- `mul_din1`  out  6  multiplier B operand; equals `in_b`.
- `mul_dout`  in  19  multiplier product.
- `out_valid`  out  1  row result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  saturated row sum.
- `out_cnt`  out  CNT_W  terms in the row, saturating.
- `out_sat`  out  1  sum or count saturated in this row.

## Operation
- Stall:
  - `stall = out_valid & ~out_ready`.
  - `mul_ce = ~stall`.
  - `in_ready = ~stall & ~clear`.
  - `mul_din0`/`mul_din1` are combinational pass-throughs of `in_a`/`in_b`.
- Validity tracking:
  - Two-stage shift register `v1`, `v2` mirrors the multiplier's `a_reg` and `p_reg` stages, with matching `l1`, `l2` for `in_last`.
  - The registers advance only when `mul_ce=1`.
  - `v1` loads `in_valid & in_ready`.
  - `mul_dout` is meaningful only when `v2=1`.
- Accumulate when `v2 & mul_ce`:
  - `acc_next = acc + mul_dout`, zero-extended.
  - If the sum exceeds `2^ACC_W-1`, clamp to that value and set the sticky row flag `sat_r`.
  - `cnt_next = cnt + 1`, saturating at `2^CNT_W-1`, which also sets `sat_r`.
  - If `l2=0`: update `acc`, `cnt` and `sat_r`.
  - If `l2=1`:
    - Load `out_sum ← acc_next`, `out_cnt ← cnt_next`, `out_sat ← sat_r | new saturation`.
    - Set `out_valid ← 1`.
    - Clear `acc`, `cnt` and `sat_r` to 0.
- Output handshake:
  - `out_valid` clears on `out_valid & out_ready` unless a new last term completes on the same edge; in that case it stays 1 with the new values.
  - While `out_valid=1`, the output fields are stable.
- Implicit row state:
  - IDLE: `cnt=0`, `v1=v2=0`.
  - RUN: terms in flight or accumulated.
  - HOLD: `stall=1`.
  - IDLE→RUN on an accepted input; RUN→HOLD on completing a result while `out_ready=0`; HOLD→RUN/IDLE on `out_ready`.
  - In HOLD, the whole pipe (multiplier included) is frozen and nothing is lost.
- `clear` (synchronous, highest priority):
  - `v1`, `v2`, `acc`, `cnt`, `sat_r` and `out_valid` go to 0.
  - The multiplier's data registers are left as is; they are don't-care while `v2=0`.
- The multiplier's own `reset` port is tied inactive by the parent. This block does not drive it.

## Timing
- Reset (`rst_n=0`, asynchronous): `v1`, `v2`, `l1`, `l2`, `acc`, `cnt`, `sat_r`, `out_valid`, `out_sum`, `out_cnt` and `out_sat` are all 0. Combinationally, `in_ready=1` and `mul_ce=1`.
- Reset asserted mid-row discards the row; no partial result is emitted.
- Latency: input accepted at edge E0 → `v1` set at E0 → `v2` and product at E1 → result registered at E2. `out_valid` is therefore high in the cycle after E2 for a single-term row.
- Throughput: one term per clock with no stall; back-to-back rows have no bubble.
- Stall cycles add exactly one cycle each to latency.
- `in_valid` held while `in_ready=0`: the operands must stay stable; they are not consumed.

## Test plan
- Reset, then a single term a=8191, b=63, last=1 → `out_valid` in the 3rd cycle after acceptance, `out_sum`=516033, `out_cnt`=1, `out_sat`=0.
- Row of 4 terms back-to-back, (3,5),(10,2),(0,63),(100,1) with last on the 4th → one result: `out_sum`=135, `out_cnt`=4; a following row of (1,1),last → `out_sum`=1 with no bubble.
- `out_ready=0` for 5 cycles while a result is pending and 2 more rows are streaming → `in_ready=0` and `mul_ce=0` during the hold; all three sums are delivered in order and correct after release.
- ACC_W=20: 3 terms of 516033 → `out_sum`=1048575, `out_sat`=1. The next row, (2,2), last → `out_sum`=4, `out_sat`=0.
- `clear` pulse while 2 terms are in flight and a result is pending → `out_valid` 0 on the next cycle; the next row of (7,7), last yields 49 with `out_cnt`=1.
- `rst_n` asserted asynchronously mid-row → all outputs 0 immediately; the row restarted after release sums correctly.

Source files
------------

// File: rtl/top_mac_row_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : top_mac_row_acc_if
// Description : Operand, multiplier and result bundle of the row accumulator.
//               slave  = accumulator side, master = parent / environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface top_mac_row_acc_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [12:0]      in_a;
  logic [5:0]       in_b;
  logic             in_last;
  logic             mul_ce;
  logic [12:0]      mul_din0;
  logic [5:0]       mul_din1;
  logic [18:0]      mul_dout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;

  modport slave (
    input  clear, in_valid, in_a, in_b, in_last, mul_dout, out_ready,
    output in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_sum, out_cnt, out_sat
  );

  modport master (
    output clear, in_valid, in_a, in_b, in_last, mul_dout, out_ready,
    input  in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_sum, out_cnt, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/top_mac_row_acc.sv
`default_nettype none
// ============================================================================
// Module      : top_mac_row_acc
// Description : Feeds a 2-cycle 13x6 multiplier, tracks term validity through
//               its pipeline and sums each row's products into a saturated
//               sum and term count delivered over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module top_mac_row_acc #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  top_mac_row_acc_if.slave    bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Validity shadow of the multiplier's input and product stages
  logic             v1_q, v2_q, l1_q, l2_q;
  // Running row state
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  // Registered result
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_sat_q;

  logic             stall;
  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             acc_ovf;
  logic             cnt_full;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;

  // A result held against downstream back-pressure freezes the whole pipe,
  // multiplier included, so no in-flight product is ever lost.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.mul_ce   = ~stall;
  assign bus.in_ready = ~stall & ~bus.clear;
  assign accept       = bus.in_valid & ~stall & ~bus.clear;
  assign bus.mul_din0 = bus.in_a;
  assign bus.mul_din1 = bus.in_b;

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_sat   = out_sat_q;

  // Saturating next values of the sum and count for the product at stage 2
  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - 19){1'b0}}, bus.mul_dout};
    acc_ovf  = sum_wide[ACC_W];
    acc_d    = acc_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_full = &cnt_q;
    cnt_d    = cnt_full ? cnt_q : cnt_q + C_CNT_ONE;
    sat_d    = sat_q | acc_ovf | cnt_full;
  end

  // Pipeline tracking, row accumulation and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (bus.clear) begin
      // Abort: drop in-flight terms, the partial row and any pending result.
      // The multiplier's data registers are don't-care while v2 is low.
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.mul_ce) begin
        v1_q <= accept;
        l1_q <= bus.in_last;
        v2_q <= v1_q;
        l2_q <= l1_q;
        if (v2_q) begin
          if (l2_q) begin
            // Row complete: publish and restart; overrides the handshake clear
            out_sum_q   <= acc_d;
            out_cnt_q   <= cnt_d;
            out_sat_q   <= sat_d;
            out_valid_q <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
